// File: rtl/slave_port_pkg.sv
// -----------------------------------------------------------------------------
// slave_port_pkg
//
// Shared serial-bus definitions used by the slave responder and by the
// arbiter's state decoding:
//   - 3-bit state encoding constants and the matching enum type
//   - default data word width (DEF_N) and slave-local address width (DEF_ADN)
//   - max_int helper for sizing counters shared by two widths
// -----------------------------------------------------------------------------
package slave_port_pkg;

  // Default data word width and slave-local address width
  localparam int DEF_N   = 8;
  localparam int DEF_ADN = 12;

  // State encodings. Encoding 7 is illegal and treated as a return to IDLE.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_WDATA = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_RREQ  = 3'd4;
  localparam logic [2:0] ST_RWAIT = 3'd5;
  localparam logic [2:0] ST_RDATA = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ADDR  = ST_ADDR,
    S_WDATA = ST_WDATA,
    S_WRITE = ST_WRITE,
    S_RREQ  = ST_RREQ,
    S_RWAIT = ST_RWAIT,
    S_RDATA = ST_RDATA
  } state_t;

  // Larger of two integers, used for sizing the shared bit counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/slave_port_shift_reg.sv
// -----------------------------------------------------------------------------
// serial_shift_reg
//
// Parameterised LSB-first shift register with parallel load and parallel out.
// Bits enter at the MSB end and move toward bit 0, so after W shifts the first
// bit received sits in bit 0. serial_out is bit 0, which makes the same block
// usable as an LSB-first serializer when a zero is shifted in behind the data.
//
// Ports:
//   clk          in   bus clock, rising edge
//   reset        in   synchronous, active-high; clears contents
//   clear        in   synchronous clear (discard partial contents)
//   load         in   parallel load of load_value (wins over shift)
//   load_value   in   W-bit parallel load value
//   shift        in   shift one position toward bit 0
//   serial_in    in   bit entering at bit W-1
//   parallel_out out  W-bit register contents
//   serial_out   out  bit 0 of the register
//
// W must be at least 2.
// -----------------------------------------------------------------------------
module serial_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         shift,
  input  logic         serial_in,
  output logic [W-1:0] parallel_out,
  output logic         serial_out
);

  logic [W-1:0] q;

  // Clear has priority over load, load over shift
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q <= '0;
    end else if (load) begin
      q <= load_value;
    end else if (shift) begin
      q <= {serial_in, q[W-1:1]};
    end
  end

  assign parallel_out = q;
  assign serial_out   = q[0];

endmodule

// File: rtl/slave_port.sv
// -----------------------------------------------------------------------------
// slave_port
//
// Serial-bus responder front end for a slave. Deserializes the address and
// write data forwarded by the arbiter, issues single-cycle parallel read and
// write strobes to local memory, and serializes read data back, LSB first.
// Supports bursts: at each word boundary burst_en continues the transaction at
// the next address (wrapping modulo 2^ADN).
//
// Ports:
//   clk        in   bus clock, all logic on rising edge
//   reset      in   synchronous, active-high
//   valid_in   in   master-side frame valid (address/data bits present)
//   wr_en      in   1 = write, 0 = read; sampled with address bit 0
//   burst_en   in   continue-burst request; sampled at each word boundary
//   address    in   serial address, LSB first
//   data_in    in   serial write data, LSB first
//   ready      out  high only while in IDLE
//   valid_out  out  serial read data valid
//   data_out   out  serial read data, LSB first
//   mem_addr   out  ADN-bit parallel word address
//   mem_wdata  out  N-bit parallel write data
//   mem_we     out  one-cycle write strobe
//   mem_re     out  one-cycle read strobe
//   mem_rdata  in   N-bit read data, valid one cycle after mem_re
//   state_out  out  current FSM state encoding
// -----------------------------------------------------------------------------
module slave_port
  import slave_port_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int ADN = DEF_ADN
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           valid_in,
  input  logic           wr_en,
  input  logic           burst_en,
  input  logic           address,
  input  logic           data_in,
  output logic           ready,
  output logic           valid_out,
  output logic           data_out,
  output logic [ADN-1:0] mem_addr,
  output logic [N-1:0]   mem_wdata,
  output logic           mem_we,
  output logic           mem_re,
  input  logic [N-1:0]   mem_rdata,
  output logic [2:0]     state_out
);

  // One counter serves address, write-data and read-data phases
  localparam int CW = $clog2(max_int(N, ADN));

  // Bit 0 of the address is taken in IDLE, so ADDR counts ADN-1 cycles
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADN - 2);
  localparam logic [CW-1:0] DATA_LAST = CW'(N - 1);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           wr_flag;

  // Shift register controls
  logic           addr_shift;
  logic           addr_clear;
  logic           addr_load;
  logic [ADN-1:0] addr_next;
  logic           wdata_shift;
  logic           wdata_clear;
  logic           rd_load;
  logic           rd_shift;

  logic [ADN-1:0] addr_q;
  logic [N-1:0]   wdata_q;

  // Taps of the shift registers that this port has no use for
  logic           addr_serial_unused;
  logic           wdata_serial_unused;
  logic [N-1:0]   rd_parallel_unused;

  logic           abort;
  logic           data_last;

  // A frame is abandoned when valid_in drops while bits are still expected
  assign abort     = ((state == S_ADDR) || (state == S_WDATA)) && !valid_in;
  assign data_last = (cnt == DATA_LAST);
  assign addr_next = addr_q + ADN'(1);

  // Shift register control derived from the current state and inputs. The
  // burst address increment reuses the address register's parallel load, so
  // mem_addr stays stable through WRITE/RREQ and steps only at word
  // boundaries.
  always_comb begin
    addr_shift  = 1'b0;
    addr_clear  = 1'b0;
    addr_load   = 1'b0;
    wdata_shift = 1'b0;
    wdata_clear = 1'b0;
    rd_load     = 1'b0;
    rd_shift    = 1'b0;
    case (state)
      S_IDLE: begin
        addr_shift = valid_in;
      end
      S_ADDR: begin
        addr_shift  = valid_in;
        addr_clear  = abort;
        wdata_clear = abort;
      end
      S_WDATA: begin
        wdata_shift = valid_in;
        addr_clear  = abort;
        wdata_clear = abort;
      end
      S_WRITE: begin
        addr_load = burst_en;
      end
      S_RWAIT: begin
        rd_load = 1'b1;
      end
      S_RDATA: begin
        rd_shift  = 1'b1;
        addr_load = data_last && burst_en;
      end
      default: begin
      end
    endcase
  end

  // Address deserializer; its contents drive mem_addr directly
  serial_shift_reg #(.W(ADN)) u_addr_sr (
    .clk          (clk),
    .reset        (reset),
    .clear        (addr_clear),
    .load         (addr_load),
    .load_value   (addr_next),
    .shift        (addr_shift),
    .serial_in    (address),
    .parallel_out (addr_q),
    .serial_out   (addr_serial_unused)
  );

  // Write data deserializer; its contents drive mem_wdata directly
  serial_shift_reg #(.W(N)) u_wdata_sr (
    .clk          (clk),
    .reset        (reset),
    .clear        (wdata_clear),
    .load         (1'b0),
    .load_value   ('0),
    .shift        (wdata_shift),
    .serial_in    (data_in),
    .parallel_out (wdata_q),
    .serial_out   (wdata_serial_unused)
  );

  // Read data serializer. Zeros shift in behind the word, so once the last
  // bit has gone out the register is empty and data_out idles low.
  serial_shift_reg #(.W(N)) u_rd_sr (
    .clk          (clk),
    .reset        (reset),
    .clear        (1'b0),
    .load         (rd_load),
    .load_value   (mem_rdata),
    .shift        (rd_shift),
    .serial_in    (1'b0),
    .parallel_out (rd_parallel_unused),
    .serial_out   (data_out)
  );

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign state_out = state;

  // Main FSM. Strobes and status are registered: each is set on the edge
  // that enters the state in which it must be visible, and defaults low so
  // mem_we/mem_re last exactly one cycle. The counter restarts on every
  // state entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wr_flag   <= 1'b0;
      ready     <= 1'b1;
      valid_out <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      valid_out <= 1'b0;
      ready     <= 1'b0;
      cnt       <= cnt + CW'(1);
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (valid_in) begin
            state   <= S_ADDR;
            wr_flag <= wr_en;
          end else begin
            ready <= 1'b1;
          end
        end
        S_ADDR: begin
          if (!valid_in) begin
            state <= S_IDLE;
            ready <= 1'b1;
            cnt   <= '0;
          end else if (cnt == ADDR_LAST) begin
            cnt <= '0;
            if (wr_flag) begin
              state <= S_WDATA;
            end else begin
              state  <= S_RREQ;
              mem_re <= 1'b1;
            end
          end
        end
        S_WDATA: begin
          if (!valid_in) begin
            state <= S_IDLE;
            ready <= 1'b1;
            cnt   <= '0;
          end else if (data_last) begin
            state  <= S_WRITE;
            mem_we <= 1'b1;
            cnt    <= '0;
          end
        end
        S_WRITE: begin
          cnt <= '0;
          if (burst_en) begin
            state <= S_WDATA;
          end else begin
            state <= S_IDLE;
            ready <= 1'b1;
          end
        end
        S_RREQ: begin
          state <= S_RWAIT;
          cnt   <= '0;
        end
        S_RWAIT: begin
          state     <= S_RDATA;
          valid_out <= 1'b1;
          cnt       <= '0;
        end
        S_RDATA: begin
          if (data_last) begin
            cnt <= '0;
            if (burst_en) begin
              state  <= S_RREQ;
              mem_re <= 1'b1;
            end else begin
              state <= S_IDLE;
              ready <= 1'b1;
            end
          end else begin
            valid_out <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slave_port.sv
// -----------------------------------------------------------------------------
// tb_slave_port
//
// Directed bench for slave_port. Each test drives one serial frame cycle by
// cycle (cycle 0 = first valid_in), logs strobes, serial output bits and
// per-cycle state/ready, then compares the logs with hand-computed values.
// A small memory model answers mem_re one cycle later; outside that cycle
// mem_rdata carries filler so a mistimed load is visible.
// -----------------------------------------------------------------------------
module tb_slave_port;
  import slave_port_pkg::*;

  localparam int N   = 8;
  localparam int ADN = 12;

  logic           clk = 1'b0;
  logic           reset;
  logic           valid_in;
  logic           wr_en;
  logic           burst_en;
  logic           address;
  logic           data_in;
  logic           ready;
  logic           valid_out;
  logic           data_out;
  logic [ADN-1:0] mem_addr;
  logic [N-1:0]   mem_wdata;
  logic           mem_we;
  logic           mem_re;
  logic [N-1:0]   mem_rdata;
  logic [2:0]     state_out;

  always #5 clk = ~clk;

  slave_port #(.N(N), .ADN(ADN)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .wr_en     (wr_en),
    .burst_en  (burst_en),
    .address   (address),
    .data_in   (data_in),
    .ready     (ready),
    .valid_out (valid_out),
    .data_out  (data_out),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .state_out (state_out)
  );

  int total = 0;
  int bad   = 0;
  int cyc;

  logic [N-1:0]   mem_model [0:(1<<ADN)-1];
  logic           last_re;
  logic [ADN-1:0] last_addr;

  int             we_count;
  int             we_cycle [4];
  logic [ADN-1:0] we_addr  [4];
  logic [N-1:0]   we_data  [4];
  int             re_count;
  int             re_cycle [4];
  logic [ADN-1:0] re_addr  [4];
  int             vo_count;
  int             vo_cycle [32];
  logic           vo_bit   [32];
  logic [2:0]     state_log [64];
  logic           ready_log [64];
  logic           valid_log [64];
  logic           dout_log  [64];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  task automatic start_test();
    cyc      = 0;
    we_count = 0;
    re_count = 0;
    vo_count = 0;
    last_re  = 1'b0;
  endtask

  // Called at a falling edge: log this cycle's outputs, present the memory
  // response and the inputs for this cycle, then move to the next cycle.
  task automatic applyStimulus(input logic rst, input logic v, input logic w,
                               input logic b, input logic a, input logic d);
    if (cyc < 64) begin
      state_log[cyc] = state_out;
      ready_log[cyc] = ready;
      valid_log[cyc] = valid_out;
      dout_log[cyc]  = data_out;
    end
    if (mem_we) begin
      if (we_count < 4) begin
        we_cycle[we_count] = cyc;
        we_addr[we_count]  = mem_addr;
        we_data[we_count]  = mem_wdata;
      end
      we_count++;
    end
    if (mem_re) begin
      if (re_count < 4) begin
        re_cycle[re_count] = cyc;
        re_addr[re_count]  = mem_addr;
      end
      re_count++;
    end
    if (valid_out) begin
      if (vo_count < 32) begin
        vo_cycle[vo_count] = cyc;
        vo_bit[vo_count]   = data_out;
      end
      vo_count++;
    end
    mem_rdata = last_re ? mem_model[last_addr] : 8'hEE;
    last_re   = mem_re;
    last_addr = mem_addr;
    reset     = rst;
    valid_in  = v;
    wr_en     = w;
    burst_en  = b;
    address   = a;
    data_in   = d;
    @(negedge clk);
    cyc++;
  endtask

  task automatic send_addr(input logic w, input logic b, input logic [ADN-1:0] addr);
    for (int i = 0; i < ADN; i++) applyStimulus(1'b0, 1'b1, w, b, addr[i], 1'b0);
  endtask

  // One write word followed by its WRITE cycle, where valid_in is left low
  task automatic send_word(input logic b, input logic [N-1:0] data);
    for (int i = 0; i < N; i++) applyStimulus(1'b0, 1'b1, 1'b1, b, 1'b0, data[i]);
    applyStimulus(1'b0, 1'b0, 1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input logic b);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, b, 1'b0, 1'b0);
  endtask

  function automatic logic [N-1:0] word_from_bits(input int start);
    logic [N-1:0] w;
    w = '0;
    for (int k = 0; k < N; k++) w[k] = vo_bit[start + k];
    return w;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    valid_in  = 1'b0;
    wr_en     = 1'b0;
    burst_en  = 1'b0;
    address   = 1'b0;
    data_in   = 1'b0;
    mem_rdata = '0;
    mem_model[12'h123] = 8'hA7;
    mem_model[12'h010] = 8'h5C;
    mem_model[12'h011] = 8'hC3;
    mem_model[12'h200] = 8'hFF;
    repeat (3) @(negedge clk);

    // Reset values
    checkOutput("rst_ready",     32'(ready),     32'd1);
    checkOutput("rst_valid_out", 32'(valid_out), 32'd0);
    checkOutput("rst_data_out",  32'(data_out),  32'd0);
    checkOutput("rst_strobes",   32'({mem_we, mem_re}), 32'd0);
    checkOutput("rst_mem_addr",  32'(mem_addr),  32'd0);
    checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("rst_state",     32'(state_out), 32'(ST_IDLE));
    reset = 1'b0;
    @(negedge clk);

    // Single write 0x0A5 <- 0x3C
    start_test();
    send_addr(1'b1, 1'b0, 12'h0A5);
    send_word(1'b0, 8'h3C);
    idle(3, 1'b0);
    checkOutput("wr_we_count", 32'(we_count),    32'd1);
    checkOutput("wr_we_cycle", 32'(we_cycle[0]), 32'd20);
    checkOutput("wr_we_addr",  32'(we_addr[0]),  32'h0A5);
    checkOutput("wr_we_data",  32'(we_data[0]),  32'h3C);
    checkOutput("wr_re_count", 32'(re_count),    32'd0);
    checkOutput("wr_ready_c1", 32'(ready_log[1]), 32'd0);
    checkOutput("wr_state_c1", 32'(state_log[1]), 32'(ST_ADDR));
    checkOutput("wr_state_c12", 32'(state_log[12]), 32'(ST_WDATA));
    checkOutput("wr_state_c20", 32'(state_log[20]), 32'(ST_WRITE));
    checkOutput("wr_state_c21", 32'(state_log[21]), 32'(ST_IDLE));
    checkOutput("wr_ready_c21", 32'(ready_log[21]), 32'd1);

    // Single read 0x123 -> 0xA7
    start_test();
    send_addr(1'b0, 1'b0, 12'h123);
    idle(12, 1'b0);
    checkOutput("rd_re_count", 32'(re_count),    32'd1);
    checkOutput("rd_re_cycle", 32'(re_cycle[0]), 32'd12);
    checkOutput("rd_re_addr",  32'(re_addr[0]),  32'h123);
    checkOutput("rd_we_count", 32'(we_count),    32'd0);
    checkOutput("rd_vo_count", 32'(vo_count),    32'd8);
    checkOutput("rd_vo_first", 32'(vo_cycle[0]), 32'd14);
    checkOutput("rd_vo_last",  32'(vo_cycle[7]), 32'd21);
    checkOutput("rd_word",     32'(word_from_bits(0)), 32'hA7);
    checkOutput("rd_state_c13", 32'(state_log[13]), 32'(ST_RWAIT));
    checkOutput("rd_state_c22", 32'(state_log[22]), 32'(ST_IDLE));
    checkOutput("rd_ready_c22", 32'(ready_log[22]), 32'd1);
    checkOutput("rd_dout_c22",  32'(dout_log[22]),  32'd0);

    // Write burst of 3 from 0xFFE, wrapping to 0x000
    start_test();
    send_addr(1'b1, 1'b1, 12'hFFE);
    send_word(1'b1, 8'h11);
    send_word(1'b1, 8'h22);
    send_word(1'b0, 8'h33);
    idle(2, 1'b0);
    checkOutput("wb_we_count", 32'(we_count), 32'd3);
    checkOutput("wb_cycle0", 32'(we_cycle[0]), 32'd20);
    checkOutput("wb_cycle1", 32'(we_cycle[1]), 32'd29);
    checkOutput("wb_cycle2", 32'(we_cycle[2]), 32'd38);
    checkOutput("wb_addr0", 32'(we_addr[0]), 32'hFFE);
    checkOutput("wb_addr1", 32'(we_addr[1]), 32'hFFF);
    checkOutput("wb_addr2", 32'(we_addr[2]), 32'h000);
    checkOutput("wb_data0", 32'(we_data[0]), 32'h11);
    checkOutput("wb_data1", 32'(we_data[1]), 32'h22);
    checkOutput("wb_data2", 32'(we_data[2]), 32'h33);
    checkOutput("wb_state_c39", 32'(state_log[39]), 32'(ST_IDLE));

    // Read burst of 2 from 0x010
    start_test();
    send_addr(1'b0, 1'b0, 12'h010);
    idle(10, 1'b1);
    idle(12, 1'b0);
    checkOutput("rb_re_count", 32'(re_count), 32'd2);
    checkOutput("rb_re_cycle0", 32'(re_cycle[0]), 32'd12);
    checkOutput("rb_re_cycle1", 32'(re_cycle[1]), 32'd22);
    checkOutput("rb_re_addr0", 32'(re_addr[0]), 32'h010);
    checkOutput("rb_re_addr1", 32'(re_addr[1]), 32'h011);
    checkOutput("rb_vo_count", 32'(vo_count), 32'd16);
    checkOutput("rb_vo_end0",  32'(vo_cycle[7]), 32'd21);
    checkOutput("rb_vo_start1", 32'(vo_cycle[8]), 32'd24);
    checkOutput("rb_vo_end1",  32'(vo_cycle[15]), 32'd31);
    checkOutput("rb_word0", 32'(word_from_bits(0)), 32'h5C);
    checkOutput("rb_word1", 32'(word_from_bits(8)), 32'hC3);
    checkOutput("rb_state_c32", 32'(state_log[32]), 32'(ST_IDLE));

    // Abort after 5 address bits, then a clean write
    start_test();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b0);
    checkOutput("ab_state_c5", 32'(state_log[5]), 32'(ST_ADDR));
    checkOutput("ab_state_c6", 32'(state_log[6]), 32'(ST_IDLE));
    checkOutput("ab_ready_c6", 32'(ready_log[6]), 32'd1);
    checkOutput("ab_strobes",  32'(we_count + re_count), 32'd0);
    start_test();
    send_addr(1'b1, 1'b0, 12'h456);
    send_word(1'b0, 8'h99);
    idle(2, 1'b0);
    checkOutput("ab_we_count", 32'(we_count), 32'd1);
    checkOutput("ab_we_cycle", 32'(we_cycle[0]), 32'd20);
    checkOutput("ab_we_addr",  32'(we_addr[0]),  32'h456);
    checkOutput("ab_we_data",  32'(we_data[0]),  32'h99);

    // Reset in the middle of RDATA
    start_test();
    send_addr(1'b0, 1'b0, 12'h200);
    idle(5, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    checkOutput("rr_valid_c17", 32'(valid_log[17]), 32'd1);
    checkOutput("rr_valid_c18", 32'(valid_log[18]), 32'd0);
    checkOutput("rr_state_c18", 32'(state_log[18]), 32'(ST_IDLE));
    checkOutput("rr_ready_c18", 32'(ready_log[18]), 32'd1);
    checkOutput("rr_dout_c18",  32'(dout_log[18]),  32'd0);
    checkOutput("rr_vo_count",  32'(vo_count), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
